// File: rtl/matmul_engine_pkg.sv
// Shared types, tensor-id constants and the saturating narrow helper
// used by the matrix-multiply engine and its MAC datapath.
package matmul_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] WR_ID_A = 16'd0;
  localparam logic [15:0] WR_ID_B = 16'd1;
  localparam logic [15:0] RD_ID_C = 16'd0;
  localparam logic [15:0] RD_ID_A = 16'd1;
  localparam logic [15:0] RD_ID_B = 16'd2;

  // Clamp a 64-bit signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                    input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Combinational MAC datapath: fixed-point product, rescale, seeded accumulate
// and saturating narrow of the running accumulator back to element width.
module matmul_mac
  import matmul_engine_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] seed,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              first,
  input  logic              use_seed,
  output logic [ACC_W-1:0]  acc_next,
  output logic [DATA_W-1:0] narrow,
  output logic              sat
);

  logic signed [DATA_W-1:0]   a_s;
  logic signed [DATA_W-1:0]   b_s;
  logic signed [DATA_W-1:0]   seed_s;
  logic signed [ACC_W-1:0]    acc_s;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    term;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [63:0]         acc_wide;
  logic signed [63:0]         clamped;

  always_comb begin
    a_s     = a;
    b_s     = b;
    seed_s  = seed;
    acc_s   = acc_in;
    prod    = (2*DATA_W)'(a_s) * (2*DATA_W)'(b_s);
    prod_sh = prod >>> FRAC;
    term    = ACC_W'(prod_sh);
    if (!first)        base = acc_s;
    else if (use_seed) base = ACC_W'(seed_s);
    else               base = '0;
    acc_next = base + term;
    acc_wide = 64'(acc_s);
    clamped  = sat_narrow(acc_wide, DATA_W);
    narrow   = clamped[DATA_W-1:0];
    sat      = (clamped != acc_wide);
  end

endmodule

// File: rtl/matmul_engine.sv
// Matrix-multiply engine: C = A*B or C += A*B over row-major tensor memories,
// one MAC per cycle plus one store cycle per output element.
module matmul_engine
  import matmul_engine_pkg::*;
#(
  parameter int M      = 2,
  parameter int K      = 3,
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              accumulate,
  output logic              busy,
  output logic              done,
  output logic              sat,
  input  logic              wr_en,
  input  logic [15:0]       wr_tensor_id,
  input  logic [15:0]       wr_index,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [15:0]       rd_tensor_id,
  input  logic [15:0]       rd_index,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned SZ_A = M * K;
  localparam int unsigned SZ_B = K * N;
  localparam int unsigned SZ_C = M * N;

  logic [DATA_W-1:0] mem_a_q [SZ_A];
  logic [DATA_W-1:0] mem_a_d [SZ_A];
  logic [DATA_W-1:0] mem_b_q [SZ_B];
  logic [DATA_W-1:0] mem_b_d [SZ_B];
  logic [DATA_W-1:0] mem_c_q [SZ_C];
  logic [DATA_W-1:0] mem_c_d [SZ_C];

  state_e            state_q, state_d;
  logic [15:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic              store_q, store_d;
  logic              accum_q, accum_d;
  logic              sat_q, sat_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  logic              wr_ok, c_we;
  logic [15:0]       addr_a, addr_b, addr_c;
  logic [DATA_W-1:0] a_op, b_op, c_op;
  logic [ACC_W-1:0]  mac_next;
  logic [DATA_W-1:0] mac_narrow;
  logic              mac_sat;

  assign busy  = (state_q == ST_MAC);
  assign done  = (state_q == ST_DONE);
  assign sat   = sat_q;
  assign wr_ok = wr_en && (state_q != ST_MAC);

  assign addr_a = i_q * 16'(K) + k_q;
  assign addr_b = k_q * 16'(N) + j_q;
  assign addr_c = i_q * 16'(N) + j_q;

  always_comb begin
    a_op = '0;
    b_op = '0;
    c_op = '0;
    for (int unsigned n = 0; n < SZ_A; n++) if (addr_a == 16'(n)) a_op = mem_a_q[n];
    for (int unsigned n = 0; n < SZ_B; n++) if (addr_b == 16'(n)) b_op = mem_b_q[n];
    for (int unsigned n = 0; n < SZ_C; n++) if (addr_c == 16'(n)) c_op = mem_c_q[n];
  end

  matmul_mac #(
    .DATA_W(DATA_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .a       (a_op),
    .b       (b_op),
    .seed    (c_op),
    .acc_in  (acc_q),
    .first   (k_q == '0),
    .use_seed(accum_q),
    .acc_next(mac_next),
    .narrow  (mac_narrow),
    .sat     (mac_sat)
  );

  // Each output element takes K MAC cycles followed by one store cycle.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    store_d = store_q;
    accum_d = accum_q;
    sat_d   = sat_q;
    acc_d   = acc_q;
    c_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accum_d = accumulate;
          sat_d   = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          store_d = 1'b0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (!store_q) begin
          acc_d = mac_next;
          if (k_q == 16'(K - 1)) store_d = 1'b1;
          else                   k_d     = k_q + 16'd1;
        end else begin
          c_we    = 1'b1;
          store_d = 1'b0;
          k_d     = '0;
          if (mac_sat) sat_d = 1'b1;
          if (j_q == 16'(N - 1)) begin
            j_d = '0;
            if (i_q == 16'(M - 1)) begin
              i_d     = '0;
              state_d = ST_DONE;
            end else begin
              i_d = i_q + 16'd1;
            end
          end else begin
            j_d = j_q + 16'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    mem_c_d = mem_c_q;
    if (wr_ok && wr_tensor_id == WR_ID_A)
      for (int unsigned n = 0; n < SZ_A; n++) if (wr_index == 16'(n)) mem_a_d[n] = wr_data;
    if (wr_ok && wr_tensor_id == WR_ID_B)
      for (int unsigned n = 0; n < SZ_B; n++) if (wr_index == 16'(n)) mem_b_d[n] = wr_data;
    if (c_we)
      for (int unsigned n = 0; n < SZ_C; n++) if (addr_c == 16'(n)) mem_c_d[n] = mac_narrow;
  end

  always_comb begin
    rd_data = '0;
    case (rd_tensor_id)
      RD_ID_C: for (int unsigned n = 0; n < SZ_C; n++) if (rd_index == 16'(n)) rd_data = mem_c_q[n];
      RD_ID_A: for (int unsigned n = 0; n < SZ_A; n++) if (rd_index == 16'(n)) rd_data = mem_a_q[n];
      RD_ID_B: for (int unsigned n = 0; n < SZ_B; n++) if (rd_index == 16'(n)) rd_data = mem_b_q[n];
      default: rd_data = '0;
    endcase
  end

  // Tensor memories keep their contents across reset.
  always_ff @(posedge clock) begin
    mem_a_q <= mem_a_d;
    mem_b_q <= mem_b_d;
    mem_c_q <= mem_c_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      store_q <= 1'b0;
      accum_q <= 1'b0;
      sat_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      store_q <= store_d;
      accum_q <= accum_d;
      sat_q   <= sat_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 Parameter M, default 2, row count of A and C.
REQ-002 Parameter K, default 3, columns of A and rows of B (inner dimension).
REQ-003 Parameter N, default 2, column count of B and C.
REQ-004 Parameter DATA_W, default 16, signed fixed-point element width.
REQ-005 Parameter FRAC, default 8, fractional bits per element.
REQ-006 Parameter ACC_W, default 40, signed accumulator width; ACC_W SHALL be at least 2*DATA_W-FRAC+clog2(K)+1.
REQ-007 clock  in  1  single clock; all state changes on the rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  request to compute C = A*B; sampled in IDLE only.
REQ-010 accumulate  in  1  sampled with start; 1 gives C = C + A*B, 0 gives C = A*B.
REQ-011 busy  out  1  high while a computation is in progress.
REQ-012 done  out  1  one-cycle pulse when a computation completes.
REQ-013 sat  out  1  sticky flag: some C element saturated during the last run.
REQ-014 wr_en, wr_tensor_id[15:0], wr_index[15:0], wr_data[DATA_W-1:0]  in  tensor load port; id 0=A, 1=B.
REQ-015 rd_tensor_id[15:0], rd_index[15:0]  in  readback select; id 0=C, 1=A, 2=B.
REQ-016 rd_data  out  DATA_W  combinational readback data.

Function
REQ-017 A, B and C SHALL be stored row-major: A[i][k] at i*K+k, B[k][j] at k*N+j, C[i][j] at i*N+j.
REQ-018 States SHALL be IDLE, MAC and DONE; reset enters IDLE.
REQ-019 IDLE with start=1 SHALL latch accumulate, clear sat, zero the i/j/k counters and enter MAC.
REQ-020 Each MAC cycle SHALL form the full-width signed product A[i][k]*B[k][j], arithmetic-shift it right by FRAC, sign-extend it to ACC_W and add it to the accumulator.
REQ-021 The accumulator SHALL be seeded at k=0 with sign-extended C[i][j] when accumulate is latched, else with 0.
REQ-022 After the k=K-1 MAC cycle, the engine SHALL spend one store cycle writing C[i][j] = acc saturated to the signed DATA_W range.
REQ-023 Any store that saturates SHALL set sat.
REQ-024 Counters SHALL run k innermost, then j, then i, each wrapping to 0 at K, N and M respectively.
REQ-025 The final store (i=M-1, j=N-1) SHALL move the engine to DONE.
REQ-026 busy SHALL be high for exactly M*N*(K+1) cycles, starting the cycle after start is accepted.
REQ-027 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 Writes with wr_en SHALL be ignored while busy.
REQ-030 An unknown wr_tensor_id or an out-of-range wr_index SHALL leave all memories unchanged.
REQ-031 rd_data SHALL return 0 for an unknown rd_tensor_id or an out-of-range rd_index, and the current memory contents otherwise (including while busy).
REQ-032 A wr_en accepted in IDLE in the same cycle as start SHALL complete before computation uses that memory.

Reset
REQ-033 Asserting reset_n=0 SHALL immediately force IDLE, busy=0, done=0 and sat=0, and zero the counters and accumulator, including mid-computation.
REQ-034 Memory contents SHALL NOT be reset; C elements written before reset SHALL keep their values.

Structure
REQ-035 A shared package SHALL hold the state enum and the tensor-id constants (A=0, B=1, C=0 read, A=1 read, B=2 read).
REQ-036 The package SHALL hold a saturating-narrow function.
REQ-037 One sub-module, matmul_mac, SHALL contain the multiply, shift, accumulate and saturate datapath.
REQ-038 Everything else (control, counters, memories) SHALL be in matmul_engine.

Verification
REQ-039 Default parameters; load A=[1..6] and B=[1..6] in Q8.8; pulse start with accumulate=0 -> busy for 16 cycles, then one done pulse; C reads 0x1600, 0x1C00, 0x3100, 0x4000; sat=0.
REQ-040 Repeat with accumulate=1 -> C reads 0x2C00, 0x3800, 0x6200, 0x7FFF; sat=1.
REQ-041 Pulse start again while busy -> ignored, and busy still totals 16 cycles; wr_en to A while busy -> A unchanged on readback.
REQ-042 Drive reset_n=0 at cycle 7 of a run -> busy=0 immediately; a fresh run afterwards gives the REQ-039 results.
REQ-043 A=[-1.5 at element 0, rest 0], B=[2.0 at element 0, rest 0] -> C[0][0]=0xFD00, all other C elements 0.
REQ-044 rd_tensor_id=3, or rd_index=6 with id 1 -> rd_data=0.
